// File: rtl/sobel_row_window.sv
// ---------------------------------------------------------------------------
// sobel_row_window
//
// Purpose:
//   Sliding three-row window in front of the Sobel accelerator core. Image
//   row strips arrive one per handshake, top to bottom. The block keeps the
//   last three accepted rows and presents them as row1 (oldest/top), row2 and
//   row3 (newest/bottom). It flags when a complete window is valid and marks
//   the final window of each strip.
//
// Ports:
//   clk                  in   clock
//   reset_n              in   asynchronous active-low reset
//   srd2srow_valid       in   input row strip valid
//   srow2srd_ready       out  a row can be accepted this cycle
//   srd2srow_data        in   row strip pixels, pixel 0 in bits [7:0]
//   srd2srow_first       in   row is the first (top) row of a new strip
//   srd2srow_last        in   row is the last (bottom) row of the strip
//   sctl2srow_clear      in   synchronous clear of error flag and counter
//   srow2sacc_row1_data  out  top row of window
//   srow2sacc_row2_data  out  middle row of window
//   srow2sacc_row3_data  out  bottom row of window
//   srow2swt_valid       out  window valid
//   swt2srow_ready       in   write path consumes the window this cycle
//   srow2swt_last        out  current window is the last of its strip
//   srow2sctl_err        out  sticky protocol error
//   srow2sctl_win_count  out  windows delivered (saturating)
// ---------------------------------------------------------------------------
`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH 144
`endif

module sobel_row_window #(
  parameter int IDATA_WIDTH = `SOBEL_IDATA_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   srd2srow_valid,
  output logic                   srow2srd_ready,
  input  logic [IDATA_WIDTH-1:0] srd2srow_data,
  input  logic                   srd2srow_first,
  input  logic                   srd2srow_last,
  input  logic                   sctl2srow_clear,
  output logic [IDATA_WIDTH-1:0] srow2sacc_row1_data,
  output logic [IDATA_WIDTH-1:0] srow2sacc_row2_data,
  output logic [IDATA_WIDTH-1:0] srow2sacc_row3_data,
  output logic                   srow2swt_valid,
  input  logic                   swt2srow_ready,
  output logic                   srow2swt_last,
  output logic                   srow2sctl_err,
  output logic [CNT_WIDTH-1:0]   srow2sctl_win_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL1 = 2'd1,
    ST_FILL2 = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_valid;
  logic                   w_valid_next;
  logic                   r_last;
  logic                   w_last_next;
  logic                   w_err_set;
  logic                   w_acc;
  logic                   w_cons;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [IDATA_WIDTH-1:0] r_row1;
  logic [IDATA_WIDTH-1:0] r_row2;
  logic [IDATA_WIDTH-1:0] r_row3;

  // A new row may enter whenever the held window is empty or is leaving this
  // cycle, so a consume and an accept can overlap without a bubble.
  assign srow2srd_ready = !r_valid | swt2srow_ready;
  assign w_acc          = srd2srow_valid & srow2srd_ready;
  assign w_cons         = r_valid & swt2srow_ready;

  // Next-state and output-flag logic.
  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_last_next  = r_last;
    w_err_set    = 1'b0;

    if (w_acc) begin
      if (srd2srow_first) begin
        // A first row always restarts the strip; a first+last row is a
        // one-row strip and therefore an error.
        w_valid_next = 1'b0;
        w_last_next  = 1'b0;
        if (srd2srow_last) begin
          w_err_set    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_FILL1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            w_err_set = 1'b1;
          end
          ST_FILL1: begin
            if (srd2srow_last) begin
              w_err_set    = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_FILL2;
            end
          end
          ST_FILL2: begin
            w_state_next = ST_RUN;
            w_valid_next = 1'b1;
            w_last_next  = srd2srow_last;
          end
          ST_RUN: begin
            if (r_last) begin
              // The strip already ended: a row without first belongs to no
              // strip. The final window leaves this cycle (acc implies cons).
              w_err_set    = 1'b1;
              w_state_next = ST_IDLE;
              w_valid_next = 1'b0;
              w_last_next  = 1'b0;
            end else begin
              w_valid_next = 1'b1;
              w_last_next  = srd2srow_last;
            end
          end
          default: begin
            w_state_next = ST_IDLE;
          end
        endcase
      end
    end else if (w_cons) begin
      w_valid_next = 1'b0;
      w_last_next  = 1'b0;
      if (r_last) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      r_last  <= w_last_next;
    end
  end

  // Row shift register: moves only on an accepted row, so the window is
  // frozen while the write path stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row1 <= '0;
      r_row2 <= '0;
      r_row3 <= '0;
    end else if (w_acc) begin
      r_row1 <= r_row2;
      r_row2 <= r_row3;
      r_row3 <= srd2srow_data;
    end
  end

  // Status: clear wins over a same-cycle error set or count increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (sctl2srow_clear) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_cons && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign srow2sacc_row1_data = r_row1;
  assign srow2sacc_row2_data = r_row2;
  assign srow2sacc_row3_data = r_row3;
  assign srow2swt_valid      = r_valid;
  assign srow2swt_last       = r_last;
  assign srow2sctl_err       = r_err;
  assign srow2sctl_win_count = r_cnt;

endmodule

// File: tb/tb_sobel_row_window.sv
// ---------------------------------------------------------------------------
// tb_sobel_row_window
//
// Purpose:
//   Self-checking bench for sobel_row_window. A row-stream reference model
//   (history of accepted rows, current strip length, pending window) predicts
//   every output each cycle. Directed strips from the test plan run first,
//   followed by randomized strips, stalls and clears, then a mid-window reset.
// ---------------------------------------------------------------------------
module tb_sobel_row_window;

  localparam int W  = 144;
  localparam int CW = 4;   // small counter so saturation is reached

  logic          clk = 1'b0;
  logic          reset_n;
  logic          srd2srow_valid;
  logic          srow2srd_ready;
  logic [W-1:0]  srd2srow_data;
  logic          srd2srow_first;
  logic          srd2srow_last;
  logic          sctl2srow_clear;
  logic [W-1:0]  srow2sacc_row1_data;
  logic [W-1:0]  srow2sacc_row2_data;
  logic [W-1:0]  srow2sacc_row3_data;
  logic          srow2swt_valid;
  logic          swt2srow_ready;
  logic          srow2swt_last;
  logic          srow2sctl_err;
  logic [CW-1:0] srow2sctl_win_count;

  sobel_row_window #(
    .IDATA_WIDTH (W),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .srd2srow_valid      (srd2srow_valid),
    .srow2srd_ready      (srow2srd_ready),
    .srd2srow_data       (srd2srow_data),
    .srd2srow_first      (srd2srow_first),
    .srd2srow_last       (srd2srow_last),
    .sctl2srow_clear     (sctl2srow_clear),
    .srow2sacc_row1_data (srow2sacc_row1_data),
    .srow2sacc_row2_data (srow2sacc_row2_data),
    .srow2sacc_row3_data (srow2sacc_row3_data),
    .srow2swt_valid      (srow2swt_valid),
    .swt2srow_ready      (swt2srow_ready),
    .srow2swt_last       (srow2swt_last),
    .srow2sctl_err       (srow2sctl_err),
    .srow2sctl_win_count (srow2sctl_win_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: last three accepted rows, rows seen in current strip
  // (0 = no open strip), the window on offer and the status.
  logic [W-1:0]  h[3];
  logic [W-1:0]  m_win[3];
  logic          m_valid;
  logic          m_last;
  logic          m_err;
  logic [CW-1:0] m_cnt;
  int            m_len;

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      h[i]     = '0;
      m_win[i] = '0;
    end
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_err   = 1'b0;
    m_cnt   = '0;
    m_len   = 0;
  endfunction

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < W/8; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check ready,
  // advance the model, then wait for the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic l,
                      input logic rdy, input logic clr, output logic acc);
    logic cons;
    logic eset;
    chk("valid", W'(srow2swt_valid), W'(m_valid));
    chk("last", W'(srow2swt_last), W'(m_last));
    chk("err", W'(srow2sctl_err), W'(m_err));
    chk("win_count", W'(srow2sctl_win_count), W'(m_cnt));
    if (m_valid) begin
      chk("row1", srow2sacc_row1_data, m_win[0]);
      chk("row2", srow2sacc_row2_data, m_win[1]);
      chk("row3", srow2sacc_row3_data, m_win[2]);
    end
    srd2srow_valid  = v;
    srd2srow_data   = d;
    srd2srow_first  = f;
    srd2srow_last   = l;
    swt2srow_ready  = rdy;
    sctl2srow_clear = clr;
    #1;
    chk("ready", W'(srow2srd_ready), W'(!m_valid | rdy));
    acc  = v & (!m_valid | rdy);
    cons = m_valid & rdy;
    eset = 1'b0;
    if (cons) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
    if (acc) begin
      h[0] = h[1];
      h[1] = h[2];
      h[2] = d;
      if (f) begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (l) begin
          eset  = 1'b1;
          m_len = 0;
        end else begin
          m_len = 1;
        end
      end else if (m_len == 0) begin
        eset = 1'b1;
      end else if (m_len == 1) begin
        if (l) begin
          eset  = 1'b1;
          m_len = 0;
        end else begin
          m_len = 2;
        end
      end else begin
        m_win   = h;
        m_valid = 1'b1;
        m_last  = l;
        m_len   = l ? 0 : m_len + 1;
      end
    end
    if (clr) begin
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      m_err = m_err | eset;
      if (cons && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_row(input logic [W-1:0] d, input logic f, input logic l, input logic rdy);
    logic a;
    a = 1'b0;
    for (int k = 0; k < 50 && !a; k++) step(1'b1, d, f, l, rdy, 1'b0, a);
    if (!a) chk("accept_timeout", W'(a), W'(1));
    $display("row %0h first=%0b last=%0b accepted", d[7:0], f, l);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a;
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0, a);
  endtask

  logic         a;
  logic [W-1:0] pd;
  logic         pf, pl, has;
  int           s_left;

  initial begin
    reset_n = 1'b0;
    srd2srow_valid = 1'b0; srd2srow_data = '0; srd2srow_first = 1'b0;
    srd2srow_last = 1'b0; sctl2srow_clear = 1'b0; swt2srow_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic 4-row strip, write path always ready.
    push_row(rep(8'h01), 1'b1, 1'b0, 1'b1);
    push_row(rep(8'h02), 1'b0, 1'b0, 1'b1);
    push_row(rep(8'h03), 1'b0, 1'b0, 1'b1);
    chk("tp1_first_window", W'(srow2swt_valid), W'(1));
    push_row(rep(8'h04), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("tp1_count", W'(srow2sctl_win_count), W'(2));

    // Same stream with write-path stall after the first window.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a);
    push_row(rep(8'h01), 1'b1, 1'b0, 1'b0);
    push_row(rep(8'h02), 1'b0, 1'b0, 1'b0);
    push_row(rep(8'h03), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, rep(8'h04), 1'b0, 1'b1, 1'b0, 1'b0, a);
      chk("tp2_stalled", W'(a), W'(0));
    end
    push_row(rep(8'h04), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("tp2_count", W'(srow2sctl_win_count), W'(2));

    // Two-row strip is an error; clear removes it.
    push_row(rep(8'h11), 1'b1, 1'b0, 1'b1);
    push_row(rep(8'h12), 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("tp3_err", W'(srow2sctl_err), W'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a);
    chk("tp3_err_cleared", W'(srow2sctl_err), W'(0));

    // Orphan row while idle, then a good 3-row strip.
    push_row(rep(8'hAA), 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    push_row(rep(8'h21), 1'b1, 1'b0, 1'b1);
    push_row(rep(8'h22), 1'b0, 1'b0, 1'b1);
    push_row(rep(8'h23), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // New first after 5 rows truncates the strip.
    for (int k = 0; k < 5; k++) push_row(rep(8'(8'h30 + k)), k == 0, 1'b0, 1'b1);
    push_row(rep(8'h41), 1'b1, 1'b0, 1'b1);
    push_row(rep(8'h42), 1'b0, 1'b0, 1'b1);
    push_row(rep(8'h43), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized strips, stalls, clears.
    has = 1'b0;
    s_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!has) begin
        for (int b = 0; b < W/8; b++) pd[b*8 +: 8] = 8'($urandom);
        if (s_left == 0) begin
          if ($urandom_range(0, 9) == 0) begin
            pf = 1'b0;
            pl = 1'($urandom_range(0, 1));
          end else begin
            pf = 1'b1;
            s_left = $urandom_range(1, 6);
            pl = (s_left == 1);
            s_left--;
          end
        end else begin
          pf = 1'b0;
          if ($urandom_range(0, 19) == 0) begin
            pf = 1'b1;
            s_left = $urandom_range(1, 6);
          end
          pl = (s_left == 1);
          s_left--;
        end
        has = 1'b1;
      end
      step($urandom_range(0, 9) < 7, pd, pf, pl, $urandom_range(0, 9) < 6,
           $urandom_range(0, 199) == 0, a);
      if (a) has = 1'b0;
    end
    idle(3, 1'b1);

    // Reset while a window is held.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a);
    push_row(rep(8'h51), 1'b1, 1'b0, 1'b0);
    push_row(rep(8'h52), 1'b0, 1'b0, 1'b0);
    push_row(rep(8'h53), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", W'(srow2swt_valid), W'(0));
    chk("rst_last", W'(srow2swt_last), W'(0));
    chk("rst_row1", srow2sacc_row1_data, '0);
    chk("rst_row3", srow2sacc_row3_data, '0);
    chk("rst_err", W'(srow2sctl_err), W'(0));
    chk("rst_count", W'(srow2sctl_win_count), W'(0));
    chk("rst_ready", W'(srow2srd_ready), W'(1));
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push_row(rep(8'h61), 1'b1, 1'b0, 1'b1);
    push_row(rep(8'h62), 1'b0, 1'b0, 1'b1);
    push_row(rep(8'h63), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("post_rst_count", W'(srow2sctl_win_count), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
